// File: rtl/dshot_pkg.sv
// Shared DSHOT definitions: supported mode constants, decoder state encoding
// and the 4-bit frame checksum.
package dshot_pkg;

    localparam logic [15:0] MODE_150 = 16'd150;
    localparam logic [15:0] MODE_300 = 16'd300;
    localparam logic [15:0] MODE_600 = 16'd600;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_CHECK
    } state_t;

    // XOR of the three nibbles of the 12-bit payload (throttle + telemetry).
    function automatic logic [3:0] crc4(input logic [11:0] d);
        return d[3:0] ^ d[7:4] ^ d[11:8];
    endfunction

endpackage

// File: rtl/dshot_sync_edge.sv
// Two-flop synchronizer for the asynchronous DSHOT line, with registered
// single-cycle rise/fall pulses derived from the synchronized value only.
module dshot_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    // sh[1:0] is the synchronizer chain, sh[2] the previous synchronized value.
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= 3'b000;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sh   <= {sh[1:0], din};
            rise <= sh[1] & ~sh[2];
            fall <= ~sh[1] & sh[2];
        end
    end

endmodule

// File: rtl/dshot_decoder.sv
// DSHOT150/300/600 frame decoder: measures pulse widths, shifts in 16 bits
// MSB first and validates the frame. Define DSHOT_DECODER_CRC_EN to check the CRC.
module dshot_decoder #(
    parameter int clockFrequency = 72_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pwm,
    input  logic [15:0] i_dshot_mode,
    output logic [15:0] o_frame,
    output logic [10:0] o_throttle,
    output logic        o_telemetry,
    output logic        o_valid,
    output logic        o_crc_err,
    output logic        o_frame_err
);
    import dshot_pkg::*;

    localparam int BT_150 = clockFrequency / 150_000;
    localparam int BT_300 = clockFrequency / 300_000;
    localparam int BT_600 = clockFrequency / 600_000;
    // Wide enough to count past 2*bit_ticks at the slowest mode.
    localparam int CNT_W  = $clog2(2 * BT_150 + 2);

    logic rise, fall;

    dshot_sync_edge u_sync (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .din   (i_pwm),
        .rise  (rise),
        .fall  (fall)
    );

    state_t             state, state_n;
    logic [15:0]        shift, shift_n;
    logic [4:0]         bit_cnt, bit_n;
    logic [CNT_W-1:0]   high_cnt, high_n;
    logic [CNT_W-1:0]   low_cnt, low_n;
    logic [CNT_W-1:0]   bt_q, bt_n, bt_sel;
    logic [15:0]        frame_n;
    logic               valid_n, ferr_n;
    logic [CNT_W+2:0]   bt_x9;
    logic               is_glitch, is_one, too_long, low_timeout;

    always_comb begin
        case (i_dshot_mode)
            MODE_300: bt_sel = CNT_W'(BT_300);
            MODE_600: bt_sel = CNT_W'(BT_600);
            default:  bt_sel = CNT_W'(BT_150);
        endcase
    end

    // Thresholds compared in scaled form so no fraction of bit_ticks is truncated.
    assign bt_x9       = {bt_q, 3'b000} + {3'b000, bt_q};
    assign is_glitch   = {high_cnt, 3'b000} < {3'b000, bt_q};
    assign is_one      = {high_cnt, 4'b0000} >= {1'b0, bt_x9};
    assign too_long    = high_cnt > bt_q;
    assign low_timeout = {1'b0, low_cnt} > {bt_q, 1'b0};

`ifdef DSHOT_DECODER_CRC_EN
    logic crc_n;
`endif

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        high_n  = (&high_cnt) ? high_cnt : high_cnt + CNT_W'(1);
        low_n   = (&low_cnt) ? low_cnt : low_cnt + CNT_W'(1);
        bt_n    = bt_q;
        frame_n = o_frame;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef DSHOT_DECODER_CRC_EN
        crc_n   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_n = ST_HIGH;
                    bit_n   = 5'd0;
                    high_n  = '0;
                    bt_n    = bt_sel;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (is_glitch) begin
                        ferr_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        shift_n = {shift[14:0], is_one};
                        bit_n   = bit_cnt + 5'd1;
                        low_n   = '0;
                        state_n = (bit_cnt == 5'd15) ? ST_CHECK : ST_LOW;
                    end
                end else if (too_long) begin
                    ferr_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    high_n  = '0;
                    state_n = ST_HIGH;
                end else if (low_timeout) begin
                    ferr_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // A rise landing here is intentionally dropped.
`ifdef DSHOT_DECODER_CRC_EN
                if (crc4(shift[15:4]) == shift[3:0]) begin
                    frame_n = shift;
                    valid_n = 1'b1;
                end else begin
                    crc_n   = 1'b1;
                end
`else
                frame_n = shift;
                valid_n = 1'b1;
`endif
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            shift       <= 16'd0;
            bit_cnt     <= 5'd0;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bt_q        <= '0;
            o_frame     <= 16'd0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            bit_cnt     <= bit_n;
            high_cnt    <= high_n;
            low_cnt     <= low_n;
            bt_q        <= bt_n;
            o_frame     <= frame_n;
            o_valid     <= valid_n;
            o_frame_err <= ferr_n;
        end
    end

`ifdef DSHOT_DECODER_CRC_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) o_crc_err <= 1'b0;
        else            o_crc_err <= crc_n;
    end
`else
    assign o_crc_err = 1'b0;
`endif

    assign o_throttle  = o_frame[15:5];
    assign o_telemetry = o_frame[4];

endmodule

// File: tb/tb_dshot_decoder.sv
// Scoreboard bench for dshot_decoder: expected output events are queued as
// stimulus is driven and matched against events captured from the DUT.
module tb_dshot_decoder;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_CRC   = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] frame;
        int          cyc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm;
    logic [15:0] mode;
    logic [15:0] o_frame;
    logic [10:0] o_throttle;
    logic        o_telemetry, o_valid, o_crc_err, o_frame_err;

    ev_t         exp_q[$];
    ev_t         obs_q[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          fall_cyc;
    logic [15:0] last_good;

    dshot_decoder #(.clockFrequency(72_000_000)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_pwm        (pwm),
        .i_dshot_mode (mode),
        .o_frame      (o_frame),
        .o_throttle   (o_throttle),
        .o_telemetry  (o_telemetry),
        .o_valid      (o_valid),
        .o_crc_err    (o_crc_err),
        .o_frame_err  (o_frame_err)
    );

    always #7 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Any cycle with two pulses at once records a non-one-hot kind.
    always @(negedge clk)
        if (rst_n && (o_valid || o_crc_err || o_frame_err))
            obs_q.push_back('{{o_valid, o_crc_err, o_frame_err}, o_frame, cyc});

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // DSHOT bit: 3/4 period high for a one, 3/8 for a zero; optional +/- jit% period.
    task automatic send_bits(input logic [15:0] f, input int bt, input int jit,
                             input int first, input int last);
        for (int i = first; i >= last; i--) begin
            int per, hi;
            per = bt;
            if (jit > 0) per = bt * (100 - jit + int'($urandom_range(2 * jit))) / 100;
            hi = f[i] ? per * 3 / 4 : per * 3 / 8;
            pwm = 1'b1;
            repeat (hi) @(negedge clk);
            pwm = 1'b0;
            fall_cyc = cyc;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwm = 1'b0; mode = 16'd150;
        repeat (3) @(negedge clk);
        checks++; if (o_frame !== 16'd0) begin fails++; $display("FAIL reset_frame got %h want 0000", o_frame); end
        checks++; if (o_throttle !== 11'd0) begin fails++; $display("FAIL reset_throttle got %0d want 0", o_throttle); end
        checks++; if (o_telemetry !== 1'b0) begin fails++; $display("FAIL reset_telemetry got %b want 0", o_telemetry); end
        checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_crc_err !== 1'b0) begin fails++; $display("FAIL reset_crc_err got %b want 0", o_crc_err); end
        checks++; if (o_frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b want 0", o_frame_err); end
        rst_n = 1'b1;
        last_good = 16'd0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        ev_t e, o;
        mode = 16'd150;
        exp_q.push_back('{K_VALID, 16'h7D0A, 0});
        send_bits(16'h7D0A, 480, 0, 15, 0);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() > 0 && obs_q[0].cyc - fall_cyc !== 5) begin
            fails++; $display("FAIL basic_latency got %0d want 5", obs_q[0].cyc - fall_cyc);
        end
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL basic_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
        checks++; if (o_throttle !== 11'd1000) begin fails++; $display("FAIL basic_throttle got %0d want 1000", o_throttle); end
        checks++; if (o_telemetry !== 1'b0) begin fails++; $display("FAIL basic_telemetry got %b want 0", o_telemetry); end
        checks++; if (o_frame !== 16'h7D0A) begin fails++; $display("FAIL basic_frame got %h want 7d0a", o_frame); end
        last_good = 16'h7D0A;
    endtask

    task automatic test_back_to_back();
        ev_t e, o;
        logic [15:0] frames [3];
        frames[0] = 16'h0000; frames[1] = 16'hFFFF; frames[2] = 16'hAAAA;
        mode = 16'd600;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{K_VALID, frames[i], 0});
            send_bits(frames[i], 120, 0, 15, 0);
            if (i < 2) repeat (18000) @(negedge clk);
            else       repeat (20) @(negedge clk);
        end
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL b2b_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 16'hAAAA;
    endtask

    task automatic test_crc();
        ev_t e, o;
        mode = 16'd600;
`ifdef DSHOT_DECODER_CRC_EN
        exp_q.push_back('{K_CRC, last_good, 0});
`else
        exp_q.push_back('{K_VALID, 16'h7D00, 0});
        last_good = 16'h7D00;
`endif
        send_bits(16'h7D00, 120, 0, 15, 0);
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL crc_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL crc_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
        checks++; if (o_frame !== last_good) begin fails++; $display("FAIL crc_frame got %h want %h", o_frame, last_good); end
    endtask

    task automatic test_jitter();
        ev_t e, o;
        mode = 16'd600;
        exp_q.push_back('{K_VALID, 16'h7D0A, 0});
        send_bits(16'h7D0A, 120, 5, 15, 0);
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL jitter_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL jitter_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 16'h7D0A;
    endtask

    // Mode is latched at frame start; switching it mid-frame must not matter.
    task automatic test_mode_change();
        ev_t e, o;
        mode = 16'd600;
        exp_q.push_back('{K_VALID, 16'h0F0F, 0});
        send_bits(16'h0F0F, 120, 0, 15, 13);
        mode = 16'd150;
        send_bits(16'h0F0F, 120, 0, 12, 0);
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL mode_chg_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL mode_chg_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 16'h0F0F;
        mode = 16'd600;
    endtask

    task automatic test_truncated();
        ev_t e, o;
        int lat;
        mode = 16'd600;
        exp_q.push_back('{K_FERR, last_good, 0});
        send_bits(16'h7D0A, 120, 0, 15, 8);
        repeat (300) @(negedge clk);
        lat = (obs_q.size() > 0) ? obs_q[0].cyc - fall_cyc : -1;
        checks++;
        if (lat < 241 || lat > 248) begin fails++; $display("FAIL trunc_latency got %0d want 241..248", lat); end
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL trunc_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL trunc_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch();
        ev_t e, o;
        mode = 16'd150;
        exp_q.push_back('{K_FERR, last_good, 0});
        pwm = 1'b1;
        #30;
        pwm = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL glitch_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // 10 us high at 72 MHz = 720 cycles; abort is due once high count passes 480.
    task automatic test_long_high();
        ev_t e, o;
        int rc, lat;
        mode = 16'd150;
        exp_q.push_back('{K_FERR, last_good, 0});
        pwm = 1'b1;
        rc = cyc;
        repeat (720) @(negedge clk);
        pwm = 1'b0;
        repeat (20) @(negedge clk);
        lat = (obs_q.size() > 0) ? obs_q[0].cyc - rc : -1;
        checks++;
        if (lat < 482 || lat > 490) begin fails++; $display("FAIL long_high_latency got %0d want 482..490", lat); end
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL long_high_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL long_high_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        ev_t e, o;
        mode = 16'd600;
        send_bits(16'h7D0A, 120, 0, 15, 9);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_frame !== 16'd0) begin fails++; $display("FAIL reset_mid_frame got %h want 0000", o_frame); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back('{K_VALID, 16'h7D0A, 0});
        send_bits(16'h7D0A, 120, 0, 15, 0);
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL reset_mid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.kind !== e.kind || o.frame !== e.frame) begin fails++; $display("FAIL reset_mid_event got %b/%h want %b/%h", o.kind, o.frame, e.kind, e.frame); end
        end
        exp_q.delete(); obs_q.delete();
        last_good = 16'h7D0A;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_crc();
        test_jitter();
        test_mode_change();
        test_truncated();
        test_glitch();
        test_long_high();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
